ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger.sv | 188 ++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: triggers the sensor every period, times the echo pulse in whole centimetres.
// Optional RANGE_AVG_EN: publish the mean of the last four non-timeout results. Assumes TICKS_PER_CM >= 2.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES         = 1000,
    parameter int PERIOD_CYCLES       = 6_000_000,
    parameter int TICKS_PER_CM        = 5800,
    parameter int MAX_CM              = 400,
    parameter int RISE_TIMEOUT_CYCLES = 3_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       echo_i,
    input  logic       enable_i,
    input  logic [8:0] threshold_cm_i,
    output logic       trigger_o,
    output logic [8:0] distance_cm_o,
    output logic       distance_valid_o,
    output logic       obstacle_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);
    localparam int TMAX_A = (TRIG_CYCLES > RISE_TIMEOUT_CYCLES) ? TRIG_CYCLES : RISE_TIMEOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > TICKS_PER_CM) ? TMAX_A : TICKS_PER_CM;
    localparam int PW     = $clog2(PERIOD_CYCLES);
    localparam int TW     = $clog2(TMAX);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
    localparam logic [TW-1:0] RISE_LAST   = TW'(RISE_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_CM - 1);
    localparam logic [8:0]    MAX_V       = 9'(MAX_CM);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            echo_meta_q, echo_s_q;
    logic [PW-1:0]   period_q, period_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [8:0]      cm_q, cm_d;
    logic            res_to_q, res_to_d;
    logic            trigger_q, trigger_d;
    logic [8:0]      distance_q;
    logic            valid_q, obstacle_q, timeout_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cm_d     = cm_q;
        res_to_d = res_to_q;
        period_d = '0;
        // At the end of a period an IDLE ranger waits for a busy sensor by holding the count.
        if (enable_i) begin
            if (period_q == PERIOD_LAST)
                period_d = (state_q == S_IDLE && echo_s_q) ? PERIOD_LAST : '0;
            else
                period_d = period_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (enable_i && period_q == PERIOD_LAST && !echo_s_q) begin
                    state_d = S_TRIG;
                    timer_d = '0;
                end
            end
            S_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (echo_s_q) begin
                    // The cycle that sees the rise is already one echo-high tick.
                    state_d = S_MEAS;
                    timer_d = TW'(1);
                    cm_d    = '0;
                end else if (timer_q == RISE_LAST) begin
                    state_d  = S_DONE;
                    cm_d     = MAX_V;
                    res_to_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_MEAS: begin
                if (!echo_s_q) begin
                    state_d  = S_DONE;
                    res_to_d = 1'b0;
                end else if (cm_q == MAX_V) begin
                    state_d  = S_DONE;
                    res_to_d = 1'b1;
                end else if (timer_q == TICK_LAST) begin
                    timer_d = '0;
                    cm_d    = cm_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        trigger_d = (state_d == S_TRIG);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            period_q    <= '0;
            timer_q     <= '0;
            cm_q        <= '0;
            res_to_q    <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_meta_q <= echo_i;
            echo_s_q    <= echo_meta_q;
            period_q    <= period_d;
            timer_q     <= timer_d;
            cm_q        <= cm_d;
            res_to_q    <= res_to_d;
            trigger_q   <= trigger_d;
        end
    end

`ifdef RANGE_AVG_EN
    logic [8:0]  hist_q [4];
    logic        pend_q, pend_to_q;
    logic [10:0] sum;
    logic [8:0]  avg;

    assign sum = 11'(hist_q[0]) + 11'(hist_q[1]) + 11'(hist_q[2]) + 11'(hist_q[3]);
    assign avg = 9'(sum >> 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= MAX_V;
            pend_q     <= 1'b0;
            pend_to_q  <= 1'b0;
            distance_q <= '0;
            valid_q    <= 1'b0;
            obstacle_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pend_q    <= (state_q == S_DONE);
            pend_to_q <= res_to_q;
            if (state_q == S_DONE && !res_to_q) begin
                hist_q[0] <= cm_q;
                hist_q[1] <= hist_q[0];
                hist_q[2] <= hist_q[1];
                hist_q[3] <= hist_q[2];
            end
            valid_q <= pend_q;
            if (pend_q) begin
                distance_q <= pend_to_q ? MAX_V : avg;
                timeout_q  <= pend_to_q;
                obstacle_q <= !pend_to_q && (avg <= threshold_cm_i);
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            distance_q <= '0;
            valid_q    <= 1'b0;
            obstacle_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                distance_q <= cm_q;
                timeout_q  <= res_to_q;
                obstacle_q <= !res_to_q && (cm_q <= threshold_cm_i);
            end
        end
    end
`endif

    assign trigger_o        = trigger_q;
    assign distance_cm_o    = distance_q;
    assign distance_valid_o = valid_q;
    assign obstacle_o       = obstacle_q;
    assign timeout_o        = timeout_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with short timing parameters; results are
// scoreboarded as {distance_cm, timeout, obstacle} and checked on every strobe.
module tb_ultrasonic_ranger;
    localparam int TRIG   = 10;
    localparam int PERIOD = 2000;
    localparam int TICKS  = 10;
    localparam int MAXCM  = 100;
    localparam int RISE   = 500;
`ifdef RANGE_AVG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n, echo, enable;
    logic [8:0] thr;
    logic       trigger, valid, obstacle, timeout;
    logic [8:0] distance;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q[$];
    logic prev_valid = 1'b0;

    ultrasonic_ranger #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD), .TICKS_PER_CM(TICKS),
        .MAX_CM(MAXCM), .RISE_TIMEOUT_CYCLES(RISE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .echo_i(echo), .enable_i(enable),
        .threshold_cm_i(thr), .trigger_o(trigger), .distance_cm_o(distance),
        .distance_valid_o(valid), .obstacle_o(obstacle), .timeout_o(timeout),
        .state_o(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            logic [10:0] e;
            check("strobe_one_cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got distance %0d, expected no strobe", distance);
            end else begin
                e = exp_q.pop_front();
                check("distance_cm", distance, e[10:2]);
                check("timeout", timeout, e[1]);
                check("obstacle", obstacle, e[0]);
            end
        end
        prev_valid = valid;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input logic level, input int budget, output int cycles);
        cycles = 0;
        while (trigger !== level && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic next_trigger();
        int c;
        wait_trig(1'b1, PERIOD + 100, c);
        wait_trig(1'b0, TRIG + 10, c);
        check("trigger_width", c, TRIG);
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_echo(input int dly, input int width, input logic [10:0] expv, output int lat);
        exp_q.push_back(expv);
        repeat (dly) tick();
        echo = 1'b1;
        repeat (width) tick();
        echo = 1'b0;
        wait_valid(50, lat);
    endtask

    initial begin
        int c, lat, seen;
        rst_n = 1'b0; enable = 1'b0; echo = 1'b0; thr = 9'd30;
        repeat (3) tick();
        check("rst_trigger", trigger, 0);
        check("rst_distance", distance, 0);
        check("rst_valid", valid, 0);
        check("rst_obstacle", obstacle, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", state, 0);
        rst_n = 1'b1; enable = 1'b1;
        wait_trig(1'b1, PERIOD + 100, c);
        check("first_trigger_cycle", c, PERIOD);
        wait_trig(1'b0, TRIG + 10, c);
        check("first_trigger_width", c, TRIG);

`ifdef RANGE_AVG_EN
        run_echo(5, 100, {9'd77, 1'b0, 1'b0}, lat);
        check("echo_fall_to_valid", lat, LAT);
        next_trigger();
        run_echo(5, 200, {9'd57, 1'b0, 1'b0}, lat);
        next_trigger();
        run_echo(5, 300, {9'd40, 1'b0, 1'b0}, lat);
        next_trigger();
        run_echo(5, 400, {9'd25, 1'b0, 1'b1}, lat);
`else
        // 253 echo-high cycles -> 25 cm; threshold above, below, equal
        run_echo(5, 253, {9'd25, 1'b0, 1'b1}, lat);
        check("echo_fall_to_valid", lat, LAT);
        thr = 9'd20;
        next_trigger();
        run_echo(5, 253, {9'd25, 1'b0, 1'b0}, lat);
        thr = 9'd25;
        next_trigger();
        run_echo(5, 253, {9'd25, 1'b0, 1'b1}, lat);

        // no echo: timeout result
        next_trigger();
        exp_q.push_back({9'd100, 1'b1, 1'b0});
        wait_valid(RISE + 50, lat);
        check("rise_timeout_latency", lat, RISE + 1);

        // echo stuck high: saturation, trigger blocked until echo_s falls
        next_trigger();
        exp_q.push_back({9'd100, 1'b1, 1'b0});
        repeat (5) tick();
        echo = 1'b1;
        seen = 0;
        repeat (3000) begin
            tick();
            if (trigger === 1'b1) seen++;
        end
        check("no_trigger_while_echo", seen, 0);
        echo = 1'b0;
        c = 0;
        while (trigger !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        check("retrigger_after_echo", c, 3);
        wait_trig(1'b0, TRIG + 10, c);
        check("retrigger_width", c, TRIG);
        thr = 9'd20;
        run_echo(5, 95, {9'd9, 1'b0, 1'b1}, lat);

        // reset mid-measurement
        next_trigger();
        repeat (5) tick();
        echo = 1'b1;
        repeat (50) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_trigger", trigger, 0);
        check("midrst_distance", distance, 0);
        check("midrst_valid", valid, 0);
        check("midrst_obstacle", obstacle, 0);
        check("midrst_timeout", timeout, 0);
        check("midrst_state", state, 0);
        echo = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_trig(1'b1, PERIOD + 100, c);
        check("trigger_after_reset", c, PERIOD);
        wait_trig(1'b0, TRIG + 10, c);
        run_echo(5, 137, {9'd13, 1'b0, 1'b1}, lat);

        // enable drops mid-measurement: result still reported, no new trigger
        next_trigger();
        exp_q.push_back({9'd42, 1'b0, 1'b0});
        repeat (5) tick();
        echo = 1'b1;
        repeat (200) tick();
        enable = 1'b0;
        repeat (220) tick();
        echo = 1'b0;
        wait_valid(50, lat);
        check("disabled_fall_to_valid", lat, LAT);
        seen = 0;
        repeat (PERIOD + 500) begin
            tick();
            if (trigger === 1'b1) seen++;
        end
        check("no_trigger_when_disabled", seen, 0);
`endif

        repeat (10) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
